// File: rtl/shift_reg_sequencer_if.sv
// Requester-side bundle for shift_reg_sequencer.
// Holds two request channels plus the shared ack/rdata/busy return path.
interface shift_reg_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 3
);
    logic             req0;
    logic             dir0;
    logic [LEN_W-1:0] len0;
    logic [WIDTH-1:0] pat0;
    logic             req1;
    logic             dir1;
    logic [LEN_W-1:0] len1;
    logic [WIDTH-1:0] pat1;
    logic             ack0;
    logic             ack1;
    logic [WIDTH-1:0] rdata;
    logic             busy;

    modport master (
        output req0, dir0, len0, pat0,
        output req1, dir1, len1, pat1,
        input  ack0, ack1, rdata, busy
    );

    modport slave (
        input  req0, dir0, len0, pat0,
        input  req1, dir1, len1, pat1,
        output ack0, ack1, rdata, busy
    );
endinterface

// File: rtl/shift_reg_sequencer.sv
// Round-robin arbiter and serialiser for one bidirectional serial shift register.
// Every output is a flop; values are loaded from the state being entered.
module shift_reg_sequencer #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    shift_reg_sequencer_if.slave   bus,
    output logic                   sr_en,
    output logic                   sr_dir,
    output logic                   sr_din,
    input  logic [WIDTH-1:0]       sr_dout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_ACK     = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] len_q;
    logic [WIDTH-1:0] pat_q;
    logic             win_q;
    logic             last_q;

    logic             grant;
    logic             win;
    logic             win_dir;
    logic [LEN_W-1:0] win_len_raw;
    logic [WIDTH-1:0] win_pat;
    logic [CNT_W-1:0] win_len;

    // Requester 1 wins when alone, or when both ask and 0 was served last.
    always_comb begin
        // NOTE: every signal is assigned on every path so no latch is inferred.
        grant       = bus.req0 | bus.req1;
        win         = bus.req1 & (~bus.req0 | ~last_q);
        win_dir     = win ? bus.dir1 : bus.dir0;
        win_len_raw = win ? bus.len1 : bus.len0;
        win_pat     = win ? bus.pat1 : bus.pat0;
        if (32'(win_len_raw) > WIDTH) begin
            win_len = CNT_MAX;
        end else begin
            win_len = CNT_W'(win_len_raw);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            len_q     <= '0;
            pat_q     <= '0;
            win_q     <= 1'b0;
            last_q    <= 1'b1;
            sr_en     <= 1'b0;
            sr_dir    <= 1'b0;
            sr_din    <= 1'b0;
            bus.ack0  <= 1'b0;
            bus.ack1  <= 1'b0;
            bus.rdata <= '0;
            bus.busy  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop reading pre-edge values.
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        win_q    <= win;
                        len_q    <= win_len;
                        bit_cnt  <= '0;
                        bus.busy <= 1'b1;
                        // pat_q holds the bits still to be presented after the first one.
                        pat_q    <= win_pat >> 1;
                        if (win_len == '0) begin
                            state <= ST_CAPTURE;
                        end else begin
                            state  <= ST_SHIFT;
                            sr_en  <= 1'b1;
                            sr_dir <= win_dir;
                            sr_din <= win_pat[0];
                        end
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt == len_q - CNT_ONE) begin
                        state  <= ST_CAPTURE;
                        sr_en  <= 1'b0;
                        sr_dir <= 1'b0;
                        sr_din <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                        sr_din  <= pat_q[0];
                        pat_q   <= pat_q >> 1;
                    end
                end
                ST_CAPTURE: begin
                    bus.rdata <= sr_dout;
                    bus.ack0  <= ~win_q;
                    bus.ack1  <= win_q;
                    state     <= ST_ACK;
                end
                ST_ACK: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                    last_q   <= win_q;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Scoreboard bench: a transfer-level model predicts each ack; a monitor checks the DUT against it.
// A behavioural shift-register device closes the loop on sr_en/sr_dir/sr_din/sr_dout.
module tb_shift_reg_sequencer;
  localparam int W  = 4;
  localparam int LW = 3;

  typedef struct {
    logic         dir;
    int           len;
    logic [W-1:0] pat;
  } txn_t;

  typedef struct {
    int           id;
    logic         dir;
    int           n;
    logic [W-1:0] bits;
    logic [W-1:0] rdata;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sr_en, sr_dir, sr_din;
  logic [W-1:0] sr_q;
  logic         sr_clear;

  int total = 0;
  int bad   = 0;

  exp_t sb[$];
  txn_t t0[8];
  txn_t t1[8];
  int   model_reg;
  int   rr_last;

  always #5 clk = ~clk;

  shift_reg_sequencer_if #(.WIDTH(W), .LEN_W(LW)) bus ();

  shift_reg_sequencer #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .sr_en   (sr_en),
    .sr_dir  (sr_dir),
    .sr_din  (sr_din),
    .sr_dout (sr_q)
  );

  // External shift-register device.
  always @(posedge clk) begin
    if (sr_clear) sr_q <= '0;
    else if (sr_en) sr_q <= sr_dir ? {sr_din, sr_q[W-1:1]} : {sr_q[W-2:0], sr_din};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: arithmetic on the register value, one bit per shift.
  function automatic void predict(input int id, input txn_t t);
    exp_t e;
    int   n;
    n = (t.len > W) ? W : t.len;
    for (int i = 0; i < n; i++) begin
      int b;
      b = int'(t.pat[i]);
      if (t.dir == 1'b0) model_reg = (model_reg * 2 + b) % (1 << W);
      else               model_reg = model_reg / 2 + b * (1 << (W - 1));
    end
    e.id    = id;
    e.dir   = t.dir;
    e.n     = n;
    e.bits  = W'(int'(t.pat) & ((1 << n) - 1));
    e.rdata = W'(model_reg);
    sb.push_back(e);
  endfunction

  // Monitor
  int           cyc = 0;
  int           rise_cyc = 0;
  int           shifts = 0;
  logic [7:0]   bits = '0;
  logic         dir_seen = 1'b0;
  bit           dir_mixed = 1'b0;
  bit           prev_ack = 1'b0;
  bit           prev_busy = 1'b0;
  exp_t         mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      shifts    = 0;
      bits      = '0;
      dir_mixed = 1'b0;
      prev_ack  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      cyc++;
      if (prev_ack) begin
        check("idle_after_ack", 32'(bus.busy), 0);
        check("ack_pulse", 32'(bus.ack0 | bus.ack1), 0);
      end
      if (bus.busy && !prev_busy) begin
        rise_cyc  = cyc;
        shifts    = 0;
        bits      = '0;
        dir_mixed = 1'b0;
      end
      if (sr_en) begin
        if (shifts < 8) bits[shifts] = sr_din;
        if (shifts == 0) dir_seen = sr_dir;
        else if (sr_dir !== dir_seen) dir_mixed = 1'b1;
        shifts++;
      end else begin
        check("ctl_quiet", {30'd0, sr_dir, sr_din}, 0);
      end
      if (bus.ack0 || bus.ack1) begin
        check("single_ack", 32'(bus.ack0 & bus.ack1), 0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: ack0=%0d ack1=%0d with nothing outstanding at %0t",
                   bus.ack0, bus.ack1, $time);
        end else begin
          mon_e = sb.pop_front();
          check("ack_id", 32'(bus.ack1), mon_e.id);
          check("rdata", 32'(bus.rdata), 32'(mon_e.rdata));
          check("shift_count", shifts, mon_e.n);
          check("shift_bits", 32'(bits), 32'(mon_e.bits));
          check("ack_latency", cyc - rise_cyc, mon_e.n + 1);
          check("dir_steady", 32'(dir_mixed), 0);
          if (mon_e.n > 0) check("shift_dir", 32'(dir_seen), 32'(mon_e.dir));
        end
      end
      prev_ack  = bus.ack0 | bus.ack1;
      prev_busy = bus.busy;
    end
  end

  task automatic drive0(input txn_t t);
    bus.dir0 = t.dir;
    bus.len0 = LW'(t.len);
    bus.pat0 = t.pat;
  endtask

  task automatic drive1(input txn_t t);
    bus.dir1 = t.dir;
    bus.len1 = LW'(t.len);
    bus.pat1 = t.pat;
  endtask

  // Called just after a negedge; asserts reset mid-cycle and checks outputs drop at once.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("reset_outputs",
          {22'd0, bus.ack0, bus.ack1, bus.busy, sr_en, sr_dir, sr_din, bus.rdata}, 0);
    sr_clear = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    sr_clear  = 1'b0;
    model_reg = 0;
    rr_last   = 1;
    rst_n     = 1'b1;
  endtask

  task automatic clear_register();
    @(negedge clk);
    sr_clear = 1'b1;
    @(negedge clk);
    sr_clear  = 1'b0;
    model_reg = 0;
  endtask

  // Both requesters raise req in the same cycle; each holds it for its n transfers.
  task automatic run_batch(input int n0, input int n1);
    int p0, p1, k0, k1, w, budget;
    p0 = 0;
    p1 = 0;
    while (p0 < n0 || p1 < n1) begin
      if (p0 < n0 && p1 < n1) w = 1 - rr_last;
      else w = (p1 < n1) ? 1 : 0;
      if (w == 0) begin predict(0, t0[p0]); p0++; end
      else        begin predict(1, t1[p1]); p1++; end
      rr_last = w;
    end
    k0 = 0;
    k1 = 0;
    @(negedge clk);
    if (n0 > 0) begin drive0(t0[0]); bus.req0 = 1'b1; end
    if (n1 > 0) begin drive1(t1[0]); bus.req1 = 1'b1; end
    budget = 0;
    while ((k0 < n0 || k1 < n1) && budget < 30 * (n0 + n1) + 20) begin
      @(negedge clk);
      budget++;
      if (bus.ack0) begin
        k0++;
        if (k0 < n0) drive0(t0[k0]); else bus.req0 = 1'b0;
      end
      if (bus.ack1) begin
        k1++;
        if (k1 < n1) drive1(t1[k1]); else bus.req1 = 1'b0;
      end
    end
    if (k0 < n0 || k1 < n1) begin
      total++;
      bad++;
      $display("FAIL batch_timeout: acks0 %0d of %0d, acks1 %0d of %0d", k0, n0, k1, n1);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int seen, budget, n0, n1;
    rst_n     = 1'b1;
    sr_clear  = 1'b0;
    bus.req0  = 1'b0;
    bus.dir0  = 1'b0;
    bus.len0  = '0;
    bus.pat0  = '0;
    bus.req1  = 1'b0;
    bus.dir1  = 1'b0;
    bus.len1  = '0;
    bus.pat1  = '0;
    model_reg = 0;
    rr_last   = 1;
    #2;
    apply_reset();

    // Left shift of 1011 into a cleared register.
    clear_register();
    t0[0] = '{dir: 1'b0, len: 4, pat: 4'b1011};
    run_batch(1, 0);
    check("left_rdata", 32'(bus.rdata), 32'h d);

    // Right shift of 1011 from requester 1.
    clear_register();
    t1[0] = '{dir: 1'b1, len: 4, pat: 4'b1011};
    run_batch(0, 1);
    check("right_rdata", 32'(bus.rdata), 32'h b);

    // Contention straight after reset: grant order 0,1,0,1.
    @(negedge clk);
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      t0[i] = '{dir: 1'($urandom), len: int'($urandom_range(1, 4)), pat: W'($urandom)};
      t1[i] = '{dir: 1'($urandom), len: int'($urandom_range(1, 4)), pat: W'($urandom)};
    end
    run_batch(2, 2);

    // Boundary lengths: read-only and clamped.
    t0[0] = '{dir: 1'b0, len: 0, pat: 4'b1111};
    run_batch(1, 0);
    t0[0] = '{dir: 1'b1, len: 7, pat: 4'b0110};
    run_batch(1, 0);

    // Reset during the second shift cycle, then restart with req0 still held.
    t0[0] = '{dir: 1'b0, len: 4, pat: 4'b1001};
    @(negedge clk);
    drive0(t0[0]);
    bus.req0 = 1'b1;
    seen   = 0;
    budget = 0;
    while (seen < 2 && budget < 20) begin
      @(negedge clk);
      budget++;
      if (sr_en) seen++;
    end
    check("abort_reached_shift2", seen, 2);
    apply_reset();
    run_batch(1, 0);

    // Randomised batches with the model tracking register contents.
    for (int r = 0; r < 25; r++) begin
      n0 = int'($urandom_range(0, 3));
      n1 = int'($urandom_range(0, 3));
      if (n0 == 0 && n1 == 0) n0 = 1;
      for (int i = 0; i < 3; i++) begin
        t0[i] = '{dir: 1'($urandom), len: int'($urandom_range(0, 7)), pat: W'($urandom)};
        t1[i] = '{dir: 1'($urandom), len: int'($urandom_range(0, 7)), pat: W'($urandom)};
      end
      run_batch(n0, n1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
